// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from the registered table; training and statistics update on the clock edge.
module branch_predictor_btb #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              inv,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - 1 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [CTR_W-1:0] up_ctr;

    // PC bit 0 is always zero and carries no index or tag information
    logic unused_pc_lsb;
    assign unused_pc_lsb = &{1'b0, lookup_pc[0], upd_pc[0]};

    assign lk_idx = lookup_pc[IDX_W:1];
    assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+1];
    assign up_idx = upd_pc[IDX_W:1];
    assign up_tag = upd_pc[ADDR_W-1:IDX_W+1];

    // Prediction path: no bypass from the update port
    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
        pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + ADDR_W'(2);
    end

    // Next counter value for a hitting update
    always_comb begin
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_ctr = ctr_q[up_idx];
        if (upd_taken) begin
            if (ctr_q[up_idx] != CTR_MAX) up_ctr = ctr_q[up_idx] + CTR_W'(1);
        end else begin
            if (ctr_q[up_idx] != '0) up_ctr = ctr_q[up_idx] - CTR_W'(1);
        end
    end

    // Table storage: reset beats invalidate, invalidate beats update
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (inv) begin
            valid_q <= '0;
        end else if (upd_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr;
                if (upd_taken) target_q[up_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= CTR_WEAK;
            end
        end
    end

    // Saturating statistics, unaffected by invalidate
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (upd_valid) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
            if (upd_mispredict && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed table-driven bench for branch_predictor_btb at default parameters.
// Each vector drives one cycle of update/inv, then looks up and checks the state after the edge.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_mispredict;
    logic        inv;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    int tests = 0;
    int fails = 0;

    branch_predictor_btb dut (
        .clk            (clk),
        .rst            (rst),
        .lookup_pc      (lookup_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .inv            (inv),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        uv;
        logic [15:0] upc;
        logic        ut;
        logic [15:0] utgt;
        logic        ump;
        logic        inv;
        logic [15:0] lk;
        logic        hit;
        logic        tk;
        logic [15:0] tgt;
        logic [15:0] bc;
        logic [15:0] mc;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic uv, input logic [15:0] upc, input logic ut,
                                input logic [15:0] utgt, input logic ump, input logic iv,
                                input logic [15:0] lk, input logic hit, input logic tk,
                                input logic [15:0] tgt, input logic [15:0] bc, input logic [15:0] mc);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.ump = ump; v.inv = iv;
        v.lk = lk; v.hit = hit; v.tk = tk; v.tgt = tgt; v.bc = bc; v.mc = mc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_upd(input logic [15:0] pc, input logic t, input logic [15:0] tgt, input logic mp);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tgt; upd_mispredict = mp;
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    initial begin
        // sequential scenario from reset; counts are cumulative
        vecs[0]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0040, 0, 0, 16'h0042, 0, 0);
        vecs[1]  = mk(1, 16'h0040, 1, 16'h0100, 1, 0, 16'h0040, 1, 1, 16'h0100, 1, 1);
        vecs[2]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0060, 0, 0, 16'h0062, 1, 1);
        vecs[3]  = mk(1, 16'h0040, 0, 16'h0AAA, 1, 0, 16'h0040, 1, 0, 16'h0042, 2, 2);
        vecs[4]  = mk(1, 16'h0040, 0, 16'h0AAA, 0, 0, 16'h0040, 1, 0, 16'h0042, 3, 2);
        vecs[5]  = mk(1, 16'h0040, 0, 16'h0AAA, 0, 0, 16'h0040, 1, 0, 16'h0042, 4, 2);
        vecs[6]  = mk(1, 16'h0040, 1, 16'h0200, 0, 0, 16'h0040, 1, 0, 16'h0042, 5, 2);
        vecs[7]  = mk(1, 16'h0040, 1, 16'h0300, 0, 0, 16'h0040, 1, 1, 16'h0300, 6, 2);
        vecs[8]  = mk(1, 16'h0040, 1, 16'h0300, 0, 0, 16'h0040, 1, 1, 16'h0300, 7, 2);
        vecs[9]  = mk(1, 16'h0040, 1, 16'h0300, 0, 0, 16'h0040, 1, 1, 16'h0300, 8, 2);
        vecs[10] = mk(1, 16'h0040, 0, 16'h0AAA, 0, 0, 16'h0040, 1, 1, 16'h0300, 9, 2);
        vecs[11] = mk(1, 16'h0040, 0, 16'h0AAA, 0, 0, 16'h0040, 1, 0, 16'h0042, 10, 2);
        vecs[12] = mk(1, 16'h0080, 0, 16'h0AAA, 1, 0, 16'h0080, 0, 0, 16'h0082, 11, 3);
        vecs[13] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0040, 1, 0, 16'h0042, 11, 3);
        vecs[14] = mk(1, 16'h0060, 1, 16'h0400, 1, 0, 16'h0060, 1, 1, 16'h0400, 12, 4);
        vecs[15] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0040, 0, 0, 16'h0042, 12, 4);
        vecs[16] = mk(1, 16'h0046, 1, 16'h0500, 0, 0, 16'h0046, 1, 1, 16'h0500, 13, 4);
        vecs[17] = mk(1, 16'h0088, 1, 16'h0600, 1, 1, 16'h0088, 0, 0, 16'h008A, 14, 5);
        vecs[18] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0046, 0, 0, 16'h0048, 14, 5);
        vecs[19] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0060, 0, 0, 16'h0062, 14, 5);
        vecs[20] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'hFFFE, 0, 0, 16'h0000, 14, 5);

        rst = 1'b1; inv = 1'b0; lookup_pc = 16'h0040;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
            upd_target = vecs[i].utgt; upd_mispredict = vecs[i].ump; inv = vecs[i].inv;
            @(posedge clk);
            #1 upd_valid = 1'b0; inv = 1'b0; lookup_pc = vecs[i].lk;
            #1;
            chk($sformatf("v%0d hit", i),    32'(pred_hit),    32'(vecs[i].hit));
            chk($sformatf("v%0d taken", i),  32'(pred_taken),  32'(vecs[i].tk));
            chk($sformatf("v%0d target", i), 32'(pred_target), 32'(vecs[i].tgt));
            chk($sformatf("v%0d bcnt", i),   32'(branch_cnt),  32'(vecs[i].bc));
            chk($sformatf("v%0d mcnt", i),   32'(mispred_cnt), 32'(vecs[i].mc));
        end

        // update and lookup of the same PC in one cycle: old result now, new result next cycle
        @(negedge clk);
        lookup_pc = 16'h0040;
        upd_valid = 1'b1; upd_pc = 16'h0040; upd_taken = 1'b1; upd_target = 16'h0700; upd_mispredict = 1'b0;
        #1;
        chk("same_cycle_old_hit", 32'(pred_hit), 32'd0);
        chk("same_cycle_old_tgt", 32'(pred_target), 32'h0042);
        @(posedge clk);
        #1 upd_valid = 1'b0;
        chk("same_cycle_new_hit", 32'(pred_hit), 32'd1);
        chk("same_cycle_new_tgt", 32'(pred_target), 32'h0700);
        chk("same_cycle_bcnt", 32'(branch_cnt), 32'd15);

        // reset together with an allocating update
        @(negedge clk);
        rst = 1'b1;
        upd_valid = 1'b1; upd_pc = 16'h0046; upd_taken = 1'b1; upd_target = 16'h0800; upd_mispredict = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; upd_valid = 1'b0; lookup_pc = 16'h0040;
        #1;
        chk("rst_upd_bcnt", 32'(branch_cnt), 32'd0);
        chk("rst_upd_mcnt", 32'(mispred_cnt), 32'd0);
        chk("rst_upd_hit40", 32'(pred_hit), 32'd0);
        lookup_pc = 16'h0046;
        #1;
        chk("rst_upd_hit46", 32'(pred_hit), 32'd0);
        chk("rst_upd_tgt46", 32'(pred_target), 32'h0048);

        // statistics: three mispredicted and two correct updates
        do_upd(16'h0080, 1'b0, 16'h0000, 1'b1);
        do_upd(16'h0080, 1'b0, 16'h0000, 1'b0);
        do_upd(16'h0080, 1'b0, 16'h0000, 1'b1);
        do_upd(16'h0080, 1'b0, 16'h0000, 1'b0);
        do_upd(16'h0080, 1'b0, 16'h0000, 1'b1);
        chk("stats_bcnt", 32'(branch_cnt), 32'd5);
        chk("stats_mcnt", 32'(mispred_cnt), 32'd3);

        // drive both counters to all-ones, then check they hold
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 16'h0080; upd_taken = 1'b0; upd_mispredict = 1'b1;
        repeat (65535) @(posedge clk);
        #1 upd_valid = 1'b0;
        chk("sat_bcnt", 32'(branch_cnt), 32'hFFFF);
        chk("sat_mcnt", 32'(mispred_cnt), 32'hFFFF);
        do_upd(16'h0080, 1'b0, 16'h0000, 1'b1);
        chk("sat_hold_bcnt", 32'(branch_cnt), 32'hFFFF);
        chk("sat_hold_mcnt", 32'(mispred_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised branch target buffer with per-entry saturating direction counters for the pipelined CPU's fetch stage. Each cycle it answers a combinational lookup for the current fetch PC with a predicted next PC. It is trained by the branch-resolution stage with each branch's actual outcome. This replaces always-not-taken fetch and the flush it forces on every taken B/BR. It also keeps saturating branch and mispredict event counters for performance evaluation.

## Interface
Parameters:
- ADDR_W, 16, PC width in bits; PC bit 0 is always 0.
- ENTRIES, 16, number of BTB entries; power of two, 2 to 256.
- CTR_W, 2, direction counter width, 1 to 4.
- CNT_W, 16, width of the statistics counters.

Derived values:
- IDX_W = log2(ENTRIES).
- index = pc[IDX_W:1].
- tag = pc[ADDR_W-1:IDX_W+1].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_pc  in  ADDR_W  current fetch PC.
- pred_hit  out  1  the entry at index(lookup_pc) is valid and its tag matches.
- pred_taken  out  1  pred_hit AND the counter MSB is 1.
- pred_target  out  ADDR_W  the stored target if pred_taken, else lookup_pc+2 (mod 2^ADDR_W).
- upd_valid  in  1  an update is presented this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual branch direction.
- upd_target  in  ADDR_W  actual taken target.
- upd_mispredict  in  1  the resolved branch was mispredicted.
- inv  in  1  clear all valid bits (instruction memory reload).
- branch_cnt  out  CNT_W  number of updates accepted.
- mispred_cnt  out  CNT_W  number of mispredicted updates.

## Operation
Storage per entry: valid (1 bit), tag (ADDR_W-1-IDX_W bits), target (ADDR_W bits), counter (CTR_W bits).

Lookup:
- Purely combinational from the registered table.
- There is no bypass: an update in cycle N is visible to lookups from cycle N+1 onward.

Update (upd_valid=1 and inv=0), for entry e = index(upd_pc):
- Hit (e valid, tag matches), upd_taken=1: counter increments, saturating at 2^CTR_W-1; target is overwritten with upd_target.
- Hit, upd_taken=0: counter decrements, saturating at 0; target is unchanged; entry stays valid.
- Miss, upd_taken=1: allocate. Set valid=1, tag=tag(upd_pc), target=upd_target, counter=2^(CTR_W-1) (weakly taken). Any other entry at that index is evicted without notice.
- Miss, upd_taken=0: no table change.

Invalidate:
- inv=1 clears every valid bit at the next edge.
- If an update arrives in the same cycle, inv wins: the update is not written to the table.
- The statistics counters still count that update.

Statistics:
- On upd_valid=1, branch_cnt increments by 1.
- On upd_valid=1 and upd_mispredict=1, mispred_cnt increments by 1.
- Both saturate at all-ones.
- Neither is cleared by inv.

Reset:
- rst=1 clears all valid bits, all counters, all targets and tags, branch_cnt and mispred_cnt.
- rst has priority over inv and update in the same cycle.

## Timing
- Prediction latency: 0 cycles. The pred_* outputs depend only on lookup_pc and the current state.
- Update latency: 1 cycle. Write at the edge where upd_valid is sampled; visible in the following cycle.
- Reset values of outputs, for the cycle after rst: pred_hit=0, pred_taken=0, pred_target=lookup_pc+2, branch_cnt=0, mispred_cnt=0.
- Reset applied mid-operation: the table is empty on the next cycle regardless of any pending update.
- Wrap-around: lookup_pc = 2^ADDR_W-2 with a miss gives pred_target=0.
- At most one update per cycle. There is no handshake; an update is always accepted.

## Test plan
All scenarios use the defaults: ENTRIES=16, so index=pc[4:1] and tag=pc[15:5].

1. Reset:
   - Stimulus: rst for 2 cycles, then lookup_pc=0x0040.
   - Required: pred_hit=0, pred_taken=0, pred_target=0x0042, branch_cnt=0, mispred_cnt=0.
2. Allocate and alias:
   - Stimulus: update pc=0x0040, taken=1, target=0x0100.
   - Required, next cycle, lookup 0x0040: hit=1, taken=1, target=0x0100.
   - Required, lookup 0x0060 (same index, tag 3 vs 2): hit=0, target=0x0062.
3. Hysteresis and saturation:
   - Stimulus: from counter 10, two not-taken updates on 0x0040.
   - Required: counter 01 then 00; pred_taken=0 after the first; hit stays 1.
   - Stimulus: then four taken updates.
   - Required: counter 01, 10, 11, 11; pred_taken=1 from the second on.
4. Miss, not-taken:
   - Stimulus: update pc=0x0080, taken=0.
   - Required: lookup 0x0080 misses; branch_cnt increments.
5. Simultaneous events:
   - Update 0x0040 while looking up 0x0040: required old result in the same cycle, new result in the next cycle.
   - inv and an allocating update in the same cycle: required all lookups miss afterwards; branch_cnt still increments.
   - rst together with an update: required branch_cnt=0 and the table empty.
6. Counters:
   - Stimulus: three updates with upd_mispredict=1 and two with upd_mispredict=0.
   - Required: branch_cnt=5, mispred_cnt=3.
   - Stimulus: force branch_cnt to 0xFFFF, then another update.
   - Required: branch_cnt stays 0xFFFF.
   - Wrap-around: lookup 0xFFFE (miss) must give pred_target=0x0000.
